// File: rtl/b1_sig_pkg.sv
// B1 BOC(1,1) signal generator shared definitions.
// Code length, Gold LFSR constants and the generator state encoding.
package b1_sig_pkg;

  localparam int B1_CODE_HALF_LEN = 4092;

  localparam logic [10:0] LFSR_INIT = 11'b01010101010;

  // Bit k-1 holds register stage k of the polynomial.
  localparam logic [10:0] G1_MASK = 11'b111_1100_0001;
  localparam logic [10:0] G2_MASK = 11'b101_1001_1111;

  typedef enum logic {
    RUN  = 1'b0,
    SEEK = 1'b1
  } state_e;

  function automatic logic lfsr_fb(
    input logic [10:0] r,
    input logic [10:0] m
  );
    return ^(r & m);
  endfunction

  function automatic logic tap_bit(
    input logic [10:0] r,
    input logic [3:0]  t
  );
    logic b;
    b = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (t == 4'(i + 1)) b = r[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/b1_gold_lfsr.sv
// B1 Gold code generator: G1/G2 LFSR pair with selectable G2 taps.
// Reload has priority over step.
module b1_gold_lfsr
  import b1_sig_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       reload,
  input  logic [3:0] tap_a,
  input  logic [3:0] tap_b,
  output logic       chip
);

  logic [10:0] g1_q;
  logic [10:0] g1_d;
  logic [10:0] g2_q;
  logic [10:0] g2_d;

  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (reload) begin
      g1_d = LFSR_INIT;
      g2_d = LFSR_INIT;
    end else if (step) begin
      g1_d = {g1_q[9:0], lfsr_fb(g1_q, G1_MASK)};
      g2_d = {g2_q[9:0], lfsr_fb(g2_q, G2_MASK)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1_q <= LFSR_INIT;
      g2_q <= LFSR_INIT;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

  assign chip = g1_q[10]
              ^ tap_bit(g2_q, tap_a)
              ^ tap_bit(g2_q, tap_b);

endmodule

// File: rtl/boc_sig_gen.sv
// B1 BOC(1,1) transmit-side sample generator: Gold code, BOC
// subcarrier, nav data and square-wave carrier into 8-bit samples.
module boc_sig_gen
  import b1_sig_pkg::*;
#(
  parameter int          ACC_WIDTH     = 32,
  parameter int          PRN_PHS_WIDTH = 12,
  parameter int          CODE_HALF_LEN = B1_CODE_HALF_LEN,
  parameter int          SYM_PERIODS   = 20,
  parameter logic [7:0]  AMP           = 8'd64,
  parameter int          G2_TAP_A      = 1,
  parameter int          G2_TAP_B      = 3
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  input  logic                     rx_en,
  input  logic [ACC_WIDTH-1:0]     rx_car_fcw,
  input  logic [ACC_WIDTH-1:0]     rx_prn_fcw,
  input  logic                     rx_load,
  input  logic [PRN_PHS_WIDTH-1:0] rx_init_phs,
  input  logic                     rx_bit,
  input  logic                     rx_bit_vld,
  output logic                     tx_bit_req,
  output logic [7:0]               tx_sig,
  output logic                     tx_loc_boc,
  output logic                     tx_prn_sop,
  output logic                     tx_prn_eop,
  output logic [PRN_PHS_WIDTH-1:0] tx_prn_phs,
  output logic                     tx_bit_urun,
  output logic                     tx_rdy
);

  localparam int AW = ACC_WIDTH;
  localparam int PW = PRN_PHS_WIDTH;
  localparam int SW = (SYM_PERIODS > 1) ? $clog2(SYM_PERIODS) : 1;

  localparam logic [PW-1:0] PHS_LEN  = PW'(CODE_HALF_LEN);
  localparam logic [PW-1:0] PHS_LAST = PW'(CODE_HALF_LEN - 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_PERIODS - 1);
  localparam logic [7:0]    NEG_AMP  = 8'(~AMP + 8'd1);

  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] phs_q;
  logic [PW-1:0] phs_d;
  logic [PW-1:0] tgt_q;
  logic [PW-1:0] tgt_d;
  logic [AW-1:0] prn_acc_q;
  logic [AW-1:0] prn_acc_d;
  logic [AW-1:0] car_acc_q;
  logic [AW-1:0] car_acc_d;
  logic [SW-1:0] sym_q;
  logic [SW-1:0] sym_d;
  logic          cur_q;
  logic          cur_d;
  logic          nbit_q;
  logic          nbit_d;
  logic          nvld_q;
  logic          nvld_d;
  logic          sop_q;
  logic [7:0]    sig_q;
  logic [7:0]    sig_d;

  logic [AW:0]   prn_sum;
  logic          carry;
  logic          run;
  logic          wrap;
  logic          tick;
  logic          eop;
  logic          bnd;
  logic          accept;
  logic          urun;
  logic          chip;
  logic          loc_boc;
  logic          smp;
  logic          lfsr_step;
  logic          lfsr_reload;

  assign prn_sum = {1'b0, prn_acc_q} + {1'b0, rx_prn_fcw};
  assign carry   = prn_sum[AW];
  assign run     = (state_q == RUN);
  assign wrap    = (phs_q == PHS_LAST);
  assign eop     = run & rx_en & wrap & carry;
  assign bnd     = eop & (sym_q == SYM_LAST);
  assign accept  = rx_bit_vld & ~nvld_q;
  assign urun    = bnd & ~nvld_q & ~accept;
  assign loc_boc = chip ^ phs_q[0];
  assign smp     = loc_boc ^ cur_q ^ car_acc_q[AW-1];

  always_comb begin
    state_d     = state_q;
    phs_d       = phs_q;
    tgt_d       = tgt_q;
    prn_acc_d   = prn_acc_q;
    sym_d       = sym_q;
    tick        = 1'b0;
    lfsr_reload = 1'b0;
    if (rx_load) begin
      tgt_d       = (rx_init_phs >= PHS_LEN) ? '0 : rx_init_phs;
      phs_d       = '0;
      prn_acc_d   = '0;
      sym_d       = '0;
      lfsr_reload = 1'b1;
      state_d     = SEEK;
    end else begin
      unique case (state_q)
        RUN: begin
          if (rx_en) begin
            prn_acc_d = prn_sum[AW-1:0];
            tick      = carry;
            if (eop) begin
              sym_d = (sym_q == SYM_LAST) ? '0 : sym_q + SW'(1);
            end
          end
        end
        SEEK: begin
          // One half-chip per clock until the target phase is reached.
          if (phs_q == tgt_q) begin
            state_d = RUN;
          end else begin
            tick = 1'b1;
            if (phs_q + PW'(1) == tgt_q) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
    if (tick) begin
      phs_d = wrap ? '0 : phs_q + PW'(1);
      if (wrap) lfsr_reload = 1'b1;
    end
  end

  assign lfsr_step = tick & ~wrap & phs_q[0];

  always_comb begin
    cur_d  = cur_q;
    nbit_d = nbit_q;
    nvld_d = nvld_q;
    if (bnd) begin
      if (nvld_q) begin
        cur_d  = nbit_q;
        nvld_d = 1'b0;
      end else if (accept) begin
        cur_d = rx_bit;
      end else begin
        cur_d = 1'b0;
      end
    end else if (accept) begin
      nbit_d = rx_bit;
      nvld_d = 1'b1;
    end
  end

  always_comb begin
    car_acc_d = rx_en ? car_acc_q + rx_car_fcw : car_acc_q;
    sig_d     = sig_q;
    if (!run) begin
      sig_d = 8'h00;
    end else if (rx_en) begin
      sig_d = smp ? NEG_AMP : AMP;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state_q   <= RUN;
      phs_q     <= '0;
      tgt_q     <= '0;
      prn_acc_q <= '0;
      car_acc_q <= '0;
      sym_q     <= '0;
      cur_q     <= 1'b0;
      nbit_q    <= 1'b0;
      nvld_q    <= 1'b0;
      sop_q     <= 1'b0;
      sig_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      phs_q     <= phs_d;
      tgt_q     <= tgt_d;
      prn_acc_q <= prn_acc_d;
      car_acc_q <= car_acc_d;
      sym_q     <= sym_d;
      cur_q     <= cur_d;
      nbit_q    <= nbit_d;
      nvld_q    <= nvld_d;
      sop_q     <= eop;
      sig_q     <= sig_d;
    end
  end

  b1_gold_lfsr u_gold (
    .clk    (rx_clk),
    .rst_n  (rx_rst),
    .step   (lfsr_step),
    .reload (lfsr_reload),
    .tap_a  (4'(G2_TAP_A)),
    .tap_b  (4'(G2_TAP_B)),
    .chip   (chip)
  );

  assign tx_bit_req  = ~nvld_q;
  assign tx_sig      = sig_q;
  assign tx_loc_boc  = loc_boc;
  assign tx_prn_sop  = sop_q & run;
  assign tx_prn_eop  = eop;
  assign tx_prn_phs  = phs_q;
  assign tx_bit_urun = urun;
  assign tx_rdy      = run;

endmodule

// File: tb/tb_boc_sig_gen.sv
// Self-checking bench for boc_sig_gen: reference model with golden
// Gold-code table, sample scoreboard, seek table and directed cases.
module tb_boc_sig_gen;

  localparam int SYMP = 2;
  localparam int HL   = 4092;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        rx_en;
  logic [31:0] rx_car_fcw;
  logic [31:0] rx_prn_fcw;
  logic        rx_load;
  logic [11:0] rx_init_phs;
  logic        rx_bit;
  logic        rx_bit_vld;
  logic        tx_bit_req;
  logic [7:0]  tx_sig;
  logic        tx_loc_boc;
  logic        tx_prn_sop;
  logic        tx_prn_eop;
  logic [11:0] tx_prn_phs;
  logic        tx_bit_urun;
  logic        tx_rdy;

  always #5 rx_clk = ~rx_clk;

  boc_sig_gen #(.SYM_PERIODS(SYMP)) dut (
    .rx_clk      (rx_clk),
    .rx_rst      (rx_rst),
    .rx_en       (rx_en),
    .rx_car_fcw  (rx_car_fcw),
    .rx_prn_fcw  (rx_prn_fcw),
    .rx_load     (rx_load),
    .rx_init_phs (rx_init_phs),
    .rx_bit      (rx_bit),
    .rx_bit_vld  (rx_bit_vld),
    .tx_bit_req  (tx_bit_req),
    .tx_sig      (tx_sig),
    .tx_loc_boc  (tx_loc_boc),
    .tx_prn_sop  (tx_prn_sop),
    .tx_prn_eop  (tx_prn_eop),
    .tx_prn_phs  (tx_prn_phs),
    .tx_bit_urun (tx_bit_urun),
    .tx_rdy      (tx_rdy)
  );

  int checks   = 0;
  int failures = 0;
  int bad      = 0;
  string first = "";

  bit chips [2046];

  int unsigned m_state, m_phs, m_tgt, m_sym;
  logic [31:0] m_acc, m_car;
  bit          m_cur, m_nbit, m_nvld, m_sop;
  logic [7:0]  m_sig;
  logic [7:0]  sb [$];

  int ncyc, n_urun, sop_bad, set_bad;
  bit chk_set, prev_eop;
  int eops [$];

  task automatic chk(string nm, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic stream_chk(string nm);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s mismatches=%0d want 0 first: %s", nm, bad, first);
    end
    bad = 0;
  endtask

  task automatic mism(string nm, logic [31:0] a, logic [31:0] e);
    if (a !== e) begin
      if (bad == 0)
        first = $sformatf("%s got %0h want %0h cyc %0d", nm, a, e, ncyc);
      bad++;
    end
  endtask

  task automatic build_chips();
    bit g1 [1:11];
    bit g2 [1:11];
    bit f1, f2;
    for (int k = 1; k <= 11; k++) begin
      g1[k] = (k % 2 == 0);
      g2[k] = (k % 2 == 0);
    end
    for (int c = 0; c < 2046; c++) begin
      chips[c] = g1[11] ^ g2[1] ^ g2[3];
      f1 = g1[1] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10] ^ g1[11];
      f2 = g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[5] ^ g2[8] ^ g2[9] ^ g2[11];
      for (int k = 11; k > 1; k--) begin
        g1[k] = g1[k-1];
        g2[k] = g2[k-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_phs = 0; m_tgt = 0; m_sym = 0;
    m_acc = '0; m_car = '0;
    m_cur = 0; m_nbit = 0; m_nvld = 0; m_sop = 0;
    m_sig = 8'h00;
    sb.delete();
    sb.push_back(8'h00);
    ncyc = 0; n_urun = 0; prev_eop = 0;
    eops.delete();
  endtask

  function automatic bit model_carry();
    logic [32:0] s;
    s = {1'b0, m_acc} + {1'b0, rx_prn_fcw};
    return s[32];
  endfunction

  task automatic cyc();
    logic [32:0] sum;
    bit run, e_eop, e_bnd, acc_b, e_urun, e_loc;
    logic [7:0] sig_n;
    #1;
    ncyc++;
    sum   = {1'b0, m_acc} + {1'b0, rx_prn_fcw};
    run   = (m_state == 0);
    e_eop = run && rx_en && (m_phs == HL - 1) && sum[32];
    e_bnd = e_eop && (m_sym == SYMP - 1);
    acc_b = rx_bit_vld && !m_nvld;
    e_urun = e_bnd && !m_nvld && !acc_b;
    e_loc = chips[m_phs / 2] ^ (m_phs % 2 == 1);
    mism("phs", 32'(tx_prn_phs), m_phs);
    mism("rdy", 32'(tx_rdy), 32'(run));
    mism("req", 32'(tx_bit_req), 32'(!m_nvld));
    mism("eop", 32'(tx_prn_eop), 32'(e_eop));
    mism("sop", 32'(tx_prn_sop), 32'(m_sop && run));
    mism("urun", 32'(tx_bit_urun), 32'(e_urun));
    mism("loc", 32'(tx_loc_boc), 32'(e_loc));
    mism("sig", 32'(tx_sig), 32'(sb.pop_front()));
    if (tx_prn_eop === 1'b1) eops.push_back(ncyc);
    if (tx_bit_urun === 1'b1) n_urun++;
    if (tx_prn_sop !== prev_eop) sop_bad++;
    prev_eop = tx_prn_eop;
    if (chk_set && tx_sig !== 8'h40 && tx_sig !== 8'hC0) set_bad++;
    sig_n = 8'h00;
    if (run) sig_n = rx_en ? ((e_loc ^ m_cur ^ m_car[31]) ? 8'hC0 : 8'h40) : m_sig;
    sb.push_back(sig_n);
    m_sig = sig_n;
    m_sop = e_eop;
    if (rx_en) m_car = m_car + rx_car_fcw;
    if (e_bnd) begin
      if (m_nvld) begin
        m_cur = m_nbit; m_nvld = 0;
      end else if (acc_b) m_cur = rx_bit;
      else m_cur = 0;
    end else if (acc_b) begin
      m_nbit = rx_bit; m_nvld = 1;
    end
    if (rx_load) begin
      m_tgt = (rx_init_phs >= HL) ? 0 : rx_init_phs;
      m_phs = 0; m_acc = '0; m_sym = 0; m_state = 1;
    end else if (run) begin
      if (rx_en) begin
        m_acc = sum[31:0];
        if (sum[32]) m_phs = (m_phs == HL - 1) ? 0 : m_phs + 1;
        if (e_eop) m_sym = (m_sym == SYMP - 1) ? 0 : m_sym + 1;
      end
    end else begin
      if (m_phs == m_tgt) m_state = 0;
      else begin
        m_phs++;
        if (m_phs == m_tgt) m_state = 0;
      end
    end
    @(posedge rx_clk);
    @(negedge rx_clk);
  endtask

  task automatic do_reset();
    rx_rst = 0;
    rx_load = 0; rx_bit_vld = 0; rx_bit = 0; rx_en = 1;
    repeat (2) @(negedge rx_clk);
    rx_rst = 1;
    model_reset();
  endtask

  task automatic run_eops(string nm, int k);
    int tgt, n;
    tgt = eops.size() + k;
    n = 0;
    while (eops.size() < tgt && n < 20000) begin
      cyc();
      n++;
    end
    chk(nm, int'(eops.size() >= tgt), 1);
  endtask

  typedef struct {
    int init;
    int seek;
    int phs;
    int eop;
  } seek_vec_t;

  seek_vec_t tbl [6];

  initial begin
    int n, m, p;
    bit hit;
    logic [7:0] s;
    bit cb [20];
    bit lprev;
    int e1, e2;

    tbl[0] = '{100, 100, 100, 7984};
    tbl[1] = '{4095, 1, 0, 0};
    tbl[2] = '{0, 1, 0, 0};
    tbl[3] = '{4092, 1, 0, 0};
    tbl[4] = '{7, 7, 7, 0};
    tbl[5] = '{4091, 4091, 4091, 2};

    build_chips();
    rx_rst = 0; rx_en = 1; rx_load = 0; rx_init_phs = '0;
    rx_bit = 0; rx_bit_vld = 0;
    rx_car_fcw = '0; rx_prn_fcw = 32'h8000_0000;
    chk_set = 0; sop_bad = 0; set_bad = 0;
    #2;
    chk("rst_sig", int'(tx_sig), 0);
    chk("rst_phs", int'(tx_prn_phs), 0);
    chk("rst_rdy", int'(tx_rdy), 1);
    chk("rst_req", int'(tx_bit_req), 1);
    chk("rst_pulses", int'({tx_prn_sop, tx_prn_eop, tx_bit_urun}), 0);

    // Scenario 1: free-running code timing.
    do_reset();
    cyc();
    chk_set = 1;
    repeat (16400) cyc();
    chk_set = 0;
    e1 = (eops.size() > 0) ? eops[0] : -1;
    e2 = (eops.size() > 1) ? eops[1] - eops[0] : -1;
    chk("s1_first_eop", e1, 8184);
    chk("s1_eop_period", e2, 8184);
    chk("s1_sop_follow", sop_bad, 0);
    chk("s1_sig_set", set_bad, 0);
    stream_chk("s1_stream");

    // Seek table, including out-of-range targets.
    foreach (tbl[i]) begin
      rx_load = 1; rx_init_phs = 12'(tbl[i].init);
      cyc();
      rx_load = 0;
      n = 0;
      while (tx_rdy !== 1'b1 && n < 5000) begin
        n++;
        cyc();
      end
      chk($sformatf("seek%0d_cycles", tbl[i].init), n, tbl[i].seek);
      chk($sformatf("seek%0d_phs", tbl[i].init), int'(tx_prn_phs), tbl[i].phs);
      if (tbl[i].eop != 0) begin
        m = 0;
        hit = 0;
        while (!hit && m < 9000) begin
          m++;
          hit = tx_prn_eop;
          cyc();
        end
        chk($sformatf("seek%0d_eop", tbl[i].init), m, tbl[i].eop);
      end
      stream_chk($sformatf("seek%0d_stream", tbl[i].init));
    end

    // Reload while already seeking restarts the seek.
    rx_load = 1; rx_init_phs = 12'd50;
    cyc();
    rx_load = 0;
    repeat (9) cyc();
    rx_load = 1; rx_init_phs = 12'd20;
    cyc();
    rx_load = 0;
    n = 0;
    while (tx_rdy !== 1'b1 && n < 5000) begin
      n++;
      cyc();
    end
    chk("reseek_cycles", n, 20);
    chk("reseek_phs", int'(tx_prn_phs), 20);
    repeat (30) cyc();
    stream_chk("reseek_stream");

    // Data path with two code periods per symbol.
    do_reset();
    rx_prn_fcw = 32'hFFFF_FFFF;
    rx_bit = 1; rx_bit_vld = 1;
    cyc();
    rx_bit_vld = 0;
    chk("s4_buf_full", int'(tx_bit_req), 0);
    run_eops("s4_wait_b1", 2);
    chk("s4_buf_drained", int'(tx_bit_req), 1);
    chk("s4_no_urun", n_urun, 0);
    repeat (50) cyc();
    stream_chk("s4_inverted_stream");
    run_eops("s4_wait_b2", 2);
    chk("s4_urun_once", n_urun, 1);
    run_eops("s4_wait_e5", 1);
    n = 0;
    while (!(m_state == 0 && m_phs == HL - 1 && m_sym == SYMP - 1 &&
             model_carry()) && n < 10000) begin
      cyc();
      n++;
    end
    chk("s4_find_bnd", int'(n < 10000), 1);
    rx_bit = 1; rx_bit_vld = 1;
    cyc();
    rx_bit_vld = 0;
    chk("s4_bypass_no_urun", n_urun, 1);
    chk("s4_bypass_req", int'(tx_bit_req), 1);
    repeat (100) cyc();
    stream_chk("s4_bypass_stream");

    // Carrier at a quarter of the clock rate.
    do_reset();
    rx_prn_fcw = 32'h8000_0000;
    rx_car_fcw = 32'h4000_0000;
    lprev = 0;
    for (int i = 0; i < 21; i++) begin
      lprev = tx_loc_boc;
      cyc();
      if (i > 0) cb[i-1] = (tx_sig == 8'hC0) ^ lprev;
    end
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (cb[i] != cb[i+4]) n++;
      if (cb[i] == cb[i+2]) n++;
    end
    chk("s5_car_period4", n, 0);
    stream_chk("s5_stream");

    // Asynchronous reset mid-period, then restart and hold.
    do_reset();
    rx_prn_fcw = 32'h8000_0000;
    rx_car_fcw = '0;
    repeat (2000) cyc();
    rx_bit = 1; rx_bit_vld = 1;
    cyc();
    rx_bit_vld = 0;
    repeat (1000) cyc();
    stream_chk("s6_pre_stream");
    #3 rx_rst = 0;
    #1;
    chk("s6_rst_sig", int'(tx_sig), 0);
    chk("s6_rst_phs", int'(tx_prn_phs), 0);
    chk("s6_rst_req", int'(tx_bit_req), 1);
    repeat (2) @(negedge rx_clk);
    rx_rst = 1;
    model_reset();
    n = 0;
    while (eops.size() == 0 && n < 9000) begin
      cyc();
      n++;
    end
    chk("s6_restart_eop", (eops.size() > 0) ? eops[0] : -1, 8184);
    repeat (7) cyc();
    p = int'(tx_prn_phs);
    s = tx_sig;
    rx_en = 0;
    repeat (50) cyc();
    chk("s6_hold_phs", int'(tx_prn_phs), p);
    chk("s6_hold_sig", int'(tx_sig), int'(s));
    rx_en = 1;
    repeat (20) cyc();
    stream_chk("s6_stream");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
